// File: rtl/poscnt_pkg.sv
// poscnt_pkg: FSM state type, default parameters and counter sizing shared by encoder_position_counter
package poscnt_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_MAX_COUNT = 99;
  localparam int DEF_LOCKOUT = 1000;
  function automatic int cnt_width(input int lockout);
    return lockout > 0 ? $clog2(lockout + 1) : 1;
  endfunction
endpackage

// File: rtl/encoder_position_counter_if.sv
// encoder_position_counter_if: step inputs, clear request and position/strobe outputs of the counter
interface encoder_position_counter_if import poscnt_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic giro_pos, giro_neg, clear;
  logic [WIDTH-1:0] position;
  logic dir, step_pulse, limit_hit;
  modport master(output giro_pos, giro_neg, clear, input position, dir, step_pulse, limit_hit);
  modport slave(input giro_pos, giro_neg, clear, output position, dir, step_pulse, limit_hit);
endinterface

// File: rtl/poscnt_edge_sync.sv
// poscnt_edge_sync: 2-flop synchronizer plus rising-edge detector for one asynchronous input
module poscnt_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic [2:0] sr;
  always_ff @(posedge clk) sr <= rst ? 3'b000 : {sr[1:0], din};
  assign rise = sr[1] & ~sr[2];
endmodule

// File: rtl/encoder_position_counter.sv
// encoder_position_counter: bounded up/down position counter driven by synchronized step edges with lockout.
// Define POSCNT_WRAP_EN to wrap at the bounds instead of saturating.
module encoder_position_counter import poscnt_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_COUNT = DEF_MAX_COUNT,
  parameter int LOCKOUT = DEF_LOCKOUT
) (
  input logic clk,
  input logic rst,
  encoder_position_counter_if.slave bus
);
  localparam int CW = cnt_width(LOCKOUT);
  localparam logic [CW-1:0] LOAD = CW'(LOCKOUT > 0 ? LOCKOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t state;
  logic [CW-1:0] cnt;
  logic up, dn, step, at_bound, move, take;
  logic [WIDTH-1:0] next_pos;
  poscnt_edge_sync u_pos (.clk(clk), .rst(rst), .din(bus.giro_pos), .rise(up));
  poscnt_edge_sync u_neg (.clk(clk), .rst(rst), .din(bus.giro_neg), .rise(dn));
  always_comb begin
    step = (state == IDLE) && (up ^ dn);
    take = step && !bus.clear;
    at_bound = up ? bus.position == MAX : bus.position == '0;
  end
`ifdef POSCNT_WRAP_EN
  assign move = 1'b1;
  assign next_pos = at_bound ? (up ? '0 : MAX) : (up ? bus.position + ONE : bus.position - ONE);
`else
  assign move = ~at_bound;
  assign next_pos = at_bound ? bus.position : (up ? bus.position + ONE : bus.position - ONE);
`endif
  // clear wins over a coincident step and never starts a lockout
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.position <= '0;
      bus.dir <= 1'b0;
      bus.step_pulse <= 1'b0;
      bus.limit_hit <= 1'b0;
    end else begin
      bus.step_pulse <= take && move;
      bus.limit_hit <= take && at_bound;
      if (bus.clear) bus.position <= '0;
      else if (step) begin
        bus.position <= next_pos;
        bus.dir <= up;
      end
      if (state == LOCK) begin
        if (cnt <= CNT_ONE) begin
          state <= IDLE;
          cnt <= '0;
        end else cnt <= cnt - CNT_ONE;
      end else if (take && LOCKOUT > 0) begin
        state <= LOCK;
        cnt <= LOAD;
      end
    end
  end
endmodule

// File: tb/tb_encoder_position_counter.sv
// tb_encoder_position_counter: directed checks on a default instance and a no-lockout instance
module tb_encoder_position_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  encoder_position_counter_if #(.WIDTH(8)) b ();
  encoder_position_counter_if #(.WIDTH(8)) bf ();
  encoder_position_counter #(.WIDTH(8), .MAX_COUNT(99), .LOCKOUT(1000)) dut (.clk(clk), .rst(rst), .bus(b));
  encoder_position_counter #(.WIDTH(8), .MAX_COUNT(99), .LOCKOUT(0)) dut_fast (.clk(clk), .rst(rst), .bus(bf));

  task automatic set_in(input bit f, input logic p, input logic n, input logic c);
    if (f) begin
      bf.giro_pos = p; bf.giro_neg = n; bf.clear = c;
    end else begin
      b.giro_pos = p; b.giro_neg = n; b.clear = c;
    end
  endtask

  function automatic int strobes(input bit f);
    return f ? int'(bf.step_pulse | bf.limit_hit) : int'(b.step_pulse | b.limit_hit);
  endfunction

  // inputs rise before edge 1 and are held through edge 4; clear is asserted only for edge 3
  task automatic pulse(input bit f, input logic p, input logic n, input logic c,
                       output logic [7:0] pos, output logic sp, output logic lh, output logic d,
                       output int extra);
    extra = 0;
    @(negedge clk); set_in(f, p, n, 1'b0);
    @(posedge clk); #1; extra += strobes(f);
    @(posedge clk); #1; extra += strobes(f);
    @(negedge clk); set_in(f, p, n, c);
    @(posedge clk); #1;
    pos = f ? bf.position : b.position;
    sp = f ? bf.step_pulse : b.step_pulse;
    lh = f ? bf.limit_hit : b.limit_hit;
    d = f ? bf.dir : b.dir;
    @(negedge clk); set_in(f, p, n, 1'b0);
    @(posedge clk); #1; extra += strobes(f);
    @(negedge clk); set_in(f, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (b.position !== 8'd0) begin mismatched++; $display("FAIL reset_pos: got %0d want 0", b.position); end
    compared++; if (b.dir !== 1'b0) begin mismatched++; $display("FAIL reset_dir: got %b want 0", b.dir); end
    compared++; if ({b.step_pulse, b.limit_hit} !== 2'b00) begin mismatched++; $display("FAIL reset_strobes: got %b want 00", {b.step_pulse, b.limit_hit}); end
    compared++; if (bf.position !== 8'd0) begin mismatched++; $display("FAIL reset_pos_fast: got %0d want 0", bf.position); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_bound;
    logic [7:0] pos; logic sp, lh, d; int extra;
    for (int i = 0; i < 99; i++) begin
      @(negedge clk); bf.giro_pos = 1'b1;
      @(negedge clk); bf.giro_pos = 1'b0;
    end
    idle(5); #1;
    compared++; if (bf.position !== 8'd99) begin mismatched++; $display("FAIL fast_count: got %0d want 99", bf.position); end
    compared++; if (bf.dir !== 1'b1) begin mismatched++; $display("FAIL fast_dir: got %b want 1", bf.dir); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
`ifdef POSCNT_WRAP_EN
    compared++; if ({pos, sp, lh} !== {8'd0, 1'b1, 1'b1}) begin mismatched++; $display("FAIL upper_bound: got pos=%0d sp=%b lh=%b want pos=0 sp=1 lh=1", pos, sp, lh); end
`else
    compared++; if ({pos, sp, lh} !== {8'd99, 1'b0, 1'b1}) begin mismatched++; $display("FAIL upper_bound: got pos=%0d sp=%b lh=%b want pos=99 sp=0 lh=1", pos, sp, lh); end
`endif
    compared++; if (extra !== 0) begin mismatched++; $display("FAIL upper_bound_extra: got %0d stray strobes want 0", extra); end
    pulse(1'b1, 1'b0, 1'b1, 1'b0, pos, sp, lh, d, extra);
`ifdef POSCNT_WRAP_EN
    compared++; if ({pos, sp, lh, d} !== {8'd99, 1'b1, 1'b1, 1'b0}) begin mismatched++; $display("FAIL lower_wrap: got pos=%0d sp=%b lh=%b dir=%b want 99 1 1 0", pos, sp, lh, d); end
`else
    compared++; if ({pos, sp, lh, d} !== {8'd98, 1'b1, 1'b0, 1'b0}) begin mismatched++; $display("FAIL down_from_max: got pos=%0d sp=%b lh=%b dir=%b want 98 1 0 0", pos, sp, lh, d); end
`endif
  endtask

  task automatic test_count_up;
    logic [7:0] pos; logic sp, lh, d; int extra; int seen;
    seen = 0;
    for (int k = 1; k <= 5; k++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
      seen += int'(sp);
      compared++; if (pos !== 8'(k)) begin mismatched++; $display("FAIL count_up_pos: got %0d want %0d", pos, k); end
      compared++; if (extra !== 0 || lh !== 1'b0) begin mismatched++; $display("FAIL count_up_timing: got stray=%0d lh=%b want 0 0", extra, lh); end
      idle(1995);
    end
    compared++; if (seen !== 5) begin mismatched++; $display("FAIL count_up_strobes: got %0d want 5", seen); end
    compared++; if (b.dir !== 1'b1) begin mismatched++; $display("FAIL count_up_dir: got %b want 1", b.dir); end
  endtask

  task automatic test_count_down;
    logic [7:0] pos; logic sp, lh, d; int extra;
    for (int k = 4; k >= 3; k--) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0, pos, sp, lh, d, extra);
      compared++; if ({pos, sp, lh, d} !== {8'(k), 1'b1, 1'b0, 1'b0}) begin mismatched++; $display("FAIL count_down: got pos=%0d sp=%b lh=%b dir=%b want %0d 1 0 0", pos, sp, lh, d, k); end
      idle(1100);
    end
  endtask

  task automatic test_lockout;
    logic [7:0] pos; logic sp, lh, d; int extra;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
    compared++; if ({pos, sp} !== {8'd4, 1'b1}) begin mismatched++; $display("FAIL lockout_first: got pos=%0d sp=%b want 4 1", pos, sp); end
    for (int k = 0; k < 2; k++) begin
      idle(195);
      pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
      compared++; if ({pos, sp, lh} !== {8'd4, 1'b0, 1'b0} || extra !== 0) begin mismatched++; $display("FAIL lockout_reject: got pos=%0d sp=%b lh=%b stray=%0d want 4 0 0 0", pos, sp, lh, extra); end
    end
    idle(1100);
  endtask

  task automatic test_clear;
    logic [7:0] pos; logic sp, lh, d; int extra;
    for (int k = 0; k < 3; k++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
      idle(1100);
    end
    compared++; if (b.position !== 8'd7) begin mismatched++; $display("FAIL clear_setup: got %0d want 7", b.position); end
    pulse(1'b0, 1'b1, 1'b0, 1'b1, pos, sp, lh, d, extra);
    compared++; if ({pos, sp, lh, d} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin mismatched++; $display("FAIL clear_priority: got pos=%0d sp=%b lh=%b dir=%b want 0 0 0 1", pos, sp, lh, d); end
    idle(10);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
    compared++; if ({pos, sp} !== {8'd1, 1'b1}) begin mismatched++; $display("FAIL clear_no_lock: got pos=%0d sp=%b want 1 1", pos, sp); end
    idle(1100);
  endtask

  task automatic test_both_edges;
    logic [7:0] pos; logic sp, lh, d; int extra;
    for (int k = 0; k < 9; k++) begin
      pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
      idle(1100);
    end
    compared++; if (b.position !== 8'd10) begin mismatched++; $display("FAIL both_setup: got %0d want 10", b.position); end
    pulse(1'b0, 1'b1, 1'b1, 1'b0, pos, sp, lh, d, extra);
    compared++; if ({pos, sp, lh, d} !== {8'd10, 1'b0, 1'b0, 1'b1} || extra !== 0) begin mismatched++; $display("FAIL both_ignored: got pos=%0d sp=%b lh=%b dir=%b stray=%0d want 10 0 0 1 0", pos, sp, lh, d, extra); end
    idle(10);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
    compared++; if ({pos, sp} !== {8'd11, 1'b1}) begin mismatched++; $display("FAIL both_stays_idle: got pos=%0d sp=%b want 11 1", pos, sp); end
    idle(1100);
  endtask

  task automatic test_reset_in_lock;
    logic [7:0] pos; logic sp, lh, d; int extra;
    pulse(1'b0, 1'b1, 1'b0, 1'b0, pos, sp, lh, d, extra);
    compared++; if (pos !== 8'd12) begin mismatched++; $display("FAIL lock_entry: got %0d want 12", pos); end
    idle(50);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    compared++; if ({b.position, b.dir} !== {8'd0, 1'b0}) begin mismatched++; $display("FAIL reset_mid_lock: got pos=%0d dir=%b want 0 0", b.position, b.dir); end
    @(negedge clk); rst = 1'b0;
    idle(5);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, pos, sp, lh, d, extra);
`ifdef POSCNT_WRAP_EN
    compared++; if ({pos, sp, lh, d} !== {8'd99, 1'b1, 1'b1, 1'b0}) begin mismatched++; $display("FAIL post_reset_step: got pos=%0d sp=%b lh=%b dir=%b want 99 1 1 0", pos, sp, lh, d); end
`else
    compared++; if ({pos, sp, lh, d} !== {8'd0, 1'b0, 1'b1, 1'b0}) begin mismatched++; $display("FAIL post_reset_step: got pos=%0d sp=%b lh=%b dir=%b want 0 0 1 0", pos, sp, lh, d); end
`endif
  endtask

  initial begin
    test_reset;
    test_bound;
    test_count_up;
    test_count_down;
    test_lockout;
    test_clear;
    test_both_edges;
    test_reset_in_lock;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/encoder_position_counter.md
ENCODER_POSITION_COUNTER -- requirements
Module: encoder_position_counter

Interface
REQ-001 Parameter WIDTH, default 8: position register width, bits.
REQ-002 Parameter MAX_COUNT, default 99: upper position bound; SHALL satisfy 0 < MAX_COUNT < 2**WIDTH.
REQ-003 Parameter LOCKOUT, default 1000: clk cycles of step rejection after an accepted step; 0 disables lockout.
REQ-004 clk  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 giro_pos  in  1  clockwise indication from upstream quadrature decoder; asynchronous to clk.
REQ-007 giro_neg  in  1  counter-clockwise indication from upstream decoder; asynchronous to clk.
REQ-008 clear  in  1  synchronous request forcing position to 0.
REQ-009 position  out  WIDTH  current count, 0..MAX_COUNT.
REQ-010 dir  out  1  direction of last accepted step; 1 = up, 0 = down.
REQ-011 step_pulse  out  1  one-cycle strobe on each position change caused by a step.
REQ-012 limit_hit  out  1  one-cycle strobe when a step meets a bound.

Function
REQ-013 giro_pos and giro_neg SHALL each pass a 2-flop synchronizer followed by rising-edge detection; levels and falling edges SHALL not count.
REQ-014 Input rising with setup before clk edge 1 SHALL update position on edge 3; fixed 3-cycle latency.
REQ-015 FSM states: IDLE, LOCK. IDLE + valid edge -> step applied, enter LOCK with counter = LOCKOUT-1; LOCK decrements each cycle, returns to IDLE when counter = 0 is reached on that edge.
REQ-016 With LOCKOUT = 0 the FSM SHALL stay in IDLE and accept an edge every cycle.
REQ-017 Edges detected in LOCK SHALL be discarded, not queued.
REQ-018 Up edge: position+1, dir=1; down edge: position-1, dir=0; step_pulse=1 for that cycle.
REQ-019 Both edges detected in the same cycle SHALL be ignored: no step, no state change, no strobes.
REQ-020 Up at MAX_COUNT or down at 0: behaviour per REQ-026/027; limit_hit=1 that cycle; dir still updated; LOCK still entered.
REQ-021 clear SHALL set position=0 next edge, take priority over any simultaneous step, suppress step_pulse/limit_hit, leave dir and FSM state unchanged.
REQ-022 All arithmetic unsigned WIDTH bits; no intermediate overflow permitted.

Reset
REQ-023 rst SHALL set position=0, dir=0, step_pulse=0, limit_hit=0, state=IDLE, lockout counter=0, synchronizer and edge flops=0.
REQ-024 rst asserted mid-LOCK SHALL abort lockout; first post-reset step SHALL be accepted without lockout wait.
REQ-025 rst SHALL dominate clear and all steps.

Configuration
REQ-026 Macro POSCNT_WRAP_EN defined: up at MAX_COUNT -> 0, down at 0 -> MAX_COUNT, step_pulse=1 and limit_hit=1.
REQ-027 Macro POSCNT_WRAP_EN undefined: saturate; position unchanged at bound, step_pulse=0, limit_hit=1.

Structure
REQ-028 Package poscnt_pkg SHALL hold the FSM state enum (IDLE, LOCK) and default WIDTH/MAX_COUNT/LOCKOUT constants.
REQ-029 Sub-module poscnt_edge_sync (2-flop synchronizer + rising-edge detector, synchronous reset) SHALL be instantiated once per input.
REQ-030 Lockout counter width SHALL be $clog2(LOCKOUT+1), minimum 1.

Verification
REQ-031 Reset, 5 giro_pos pulses 2000 cycles apart -> position=5, dir=1, five step_pulse strobes, each 3 cycles after input rise.
REQ-032 position=3, giro_pos pulses 200 cycles apart x3 -> only first accepted, position=4.
REQ-033 position=99, giro_pos -> saturate: 99, limit_hit=1, step_pulse=0; WRAP_EN: 0, limit_hit=1, step_pulse=1.
REQ-034 position=10, giro_pos and giro_neg rise same cycle -> position=10, no strobes, state IDLE.
REQ-035 position=7, clear and giro_pos same cycle -> position=0, step_pulse=0.
REQ-036 rst asserted 50 cycles into LOCK, released, giro_neg 5 cycles later from position 0 -> saturate: 0 with limit_hit=1 (no lockout wait); WRAP_EN: 99.
